// File: rtl/cache_pkg.sv
// Shared types and width helpers for the N-way set-associative cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_WAIT = 3'd3,
    RESP     = 3'd4
  } state_t;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction

  function automatic int age_w(input int ways);
    return $clog2(ways);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim selection for one set (age 0 = most recently used).
module cache_lru #(
  parameter int WAYS  = 4,
  parameter int AGE_W = 2
) (
  input  logic [WAYS*AGE_W-1:0] i_ages,
  input  logic [WAYS-1:0]       i_valid,
  input  logic [AGE_W-1:0]      i_acc_way,
  output logic [WAYS*AGE_W-1:0] o_ages,
  output logic [AGE_W-1:0]      o_victim
);

  logic [AGE_W-1:0] w_acc_age;
  logic             w_found;

  always_comb begin
    w_acc_age = '0;
    o_ages    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == i_acc_way) w_acc_age = i_ages[w*AGE_W +: AGE_W];
    end
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == i_acc_way)
        o_ages[w*AGE_W +: AGE_W] = '0;
      else if (i_ages[w*AGE_W +: AGE_W] < w_acc_age)
        o_ages[w*AGE_W +: AGE_W] = i_ages[w*AGE_W +: AGE_W] + 1'b1;
      else
        o_ages[w*AGE_W +: AGE_W] = i_ages[w*AGE_W +: AGE_W];
    end
  end

  // Victim: lowest-index invalid way, otherwise the oldest way.
  always_comb begin
    o_victim = '0;
    w_found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!i_valid[w] && !w_found) begin
        o_victim = AGE_W'(w);
        w_found  = 1'b1;
      end
    end
    if (!w_found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (i_ages[w*AGE_W +: AGE_W] == AGE_W'(WAYS-1)) o_victim = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_nway.sv
// Write-through, write-allocate N-way cache with true-LRU, flush and hit/miss counters.
module cache_nway
  import cache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
  output logic [2:0]        dbg_state
);

  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS);
  localparam int AGE_W  = age_w(WAYS);
  localparam int LINE_W = IDX_W + AGE_W;
  localparam int LINES  = SETS * WAYS;

  state_t r_state, w_next;

  logic [DATA_W-1:0] r_data  [LINES];
  logic [TAG_W-1:0]  r_tag   [LINES];
  logic              r_valid [LINES];
  logic [AGE_W-1:0]  r_age   [LINES];

  logic              r_wr, r_hit, r_resp_hit, r_mem_wr;
  logic [ADDR_W-1:0] r_addr, r_mem_addr;
  logic [DATA_W-1:0] r_wdata, r_mem_wdata, r_rdata;
  logic [AGE_W-1:0]  r_way;
  logic [31:0]       r_hit_cnt, r_miss_cnt;

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [WAYS*AGE_W-1:0]  w_set_ages, w_new_ages;
  logic [WAYS-1:0]        w_set_valid;
  logic                   w_hit;
  logic [AGE_W-1:0]       w_hit_way, w_victim, w_acc_way;
  logic [LINE_W-1:0]      w_acc_line;

  assign w_idx = r_addr[IDX_W-1:0];
  assign w_tag = r_addr[ADDR_W-1:IDX_W];

  always_comb begin
    w_set_ages  = '0;
    w_set_valid = '0;
    w_hit       = 1'b0;
    w_hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      w_set_ages[w*AGE_W +: AGE_W] = r_age[{w_idx, AGE_W'(w)}];
      w_set_valid[w]               = r_valid[{w_idx, AGE_W'(w)}];
      if (r_valid[{w_idx, AGE_W'(w)}] && r_tag[{w_idx, AGE_W'(w)}] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
    end
  end

  cache_lru #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .i_ages    (w_set_ages),
    .i_valid   (w_set_valid),
    .i_acc_way (w_acc_way),
    .o_ages    (w_new_ages),
    .o_victim  (w_victim)
  );

  // In LOOKUP the way is chosen live; a later fill reuses the way picked then.
  assign w_acc_way  = (r_state == LOOKUP) ? (w_hit ? w_hit_way : w_victim) : r_way;
  assign w_acc_line = {w_idx, w_acc_way};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (!flush && req_valid) w_next = LOOKUP;
      LOOKUP:   w_next = (w_hit && !r_wr) ? RESP : MEM_REQ;
      MEM_REQ:  if (mem_req_ready) w_next = MEM_WAIT;
      MEM_WAIT: if (mem_resp_valid) w_next = RESP;
      RESP:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= 1'b0; r_hit <= 1'b0; r_resp_hit <= 1'b0; r_mem_wr <= 1'b0;
      r_addr <= '0; r_mem_addr <= '0; r_wdata <= '0; r_mem_wdata <= '0; r_rdata <= '0;
      r_way <= '0; r_hit_cnt <= '0; r_miss_cnt <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_data[i]  <= '0;
        r_tag[i]   <= '0;
        r_valid[i] <= 1'b0;
        r_age[i]   <= AGE_W'(i % WAYS);
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            for (int i = 0; i < LINES; i++) begin
              r_valid[i] <= 1'b0;
              r_age[i]   <= AGE_W'(i % WAYS);
            end
          end else if (req_valid) begin
            r_wr    <= req_wr;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
          end
        end
        LOOKUP: begin
          r_hit <= w_hit;
          r_way <= w_acc_way;
          if (w_hit) begin
            if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
          end else begin
            if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
          end
          if (w_hit || r_wr) begin
            for (int w = 0; w < WAYS; w++) r_age[{w_idx, AGE_W'(w)}] <= w_new_ages[w*AGE_W +: AGE_W];
          end
          if (r_wr) begin
            r_data[w_acc_line]  <= r_wdata;
            r_tag[w_acc_line]   <= w_tag;
            r_valid[w_acc_line] <= 1'b1;
          end
          if (w_hit && !r_wr) begin
            r_rdata    <= r_data[w_acc_line];
            r_resp_hit <= 1'b1;
          end else begin
            r_mem_wr    <= r_wr;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
          end
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            r_resp_hit <= r_hit;
            if (!r_wr) begin
              r_rdata             <= mem_resp_rdata;
              r_data[w_acc_line]  <= mem_resp_rdata;
              r_tag[w_acc_line]   <= w_tag;
              r_valid[w_acc_line] <= 1'b1;
              for (int w = 0; w < WAYS; w++) r_age[{w_idx, AGE_W'(w)}] <= w_new_ages[w*AGE_W +: AGE_W];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshakes: a request transfers on req_valid && req_ready; a memory request
  // transfers on mem_req_valid && mem_req_ready; resp_valid is a single-cycle pulse.
  assign req_ready     = (r_state == IDLE) && !rst && !flush;
  assign resp_valid    = (r_state == RESP);
  assign resp_rdata    = r_rdata;
  assign resp_hit      = r_resp_hit;
  assign mem_req_valid = (r_state == MEM_REQ);
  assign mem_req_wr    = r_mem_wr;
  assign mem_req_addr  = r_mem_addr;
  assign mem_req_wdata = r_mem_wdata;
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: a small word RAM model answers memory requests.
module tb_cache_nway;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, flush = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_wr;
  logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata = '0;
  logic [31:0] hit_count, miss_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [31:0] ram [0:255];

  int          t_n_mem, t_lat;
  logic        t_got, t_stable, t_busy_ok, t_hit, m_wr;
  logic [31:0] t_rdata, m_addr, m_wdata;

  cache_nway #(.WAYS(4), .SETS(16), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wr(mem_req_wr),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .hit_count(hit_count), .miss_count(miss_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one request and plays memory; returns at the negedge where resp_valid is seen.
  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input int ready_delay);
    int   guard, held;
    logic prev_v, pending;
    t_n_mem = 0; t_lat = 0; t_got = 0; t_stable = 1; t_busy_ok = 1; t_rdata = '0; t_hit = 0;
    guard = 0; held = 0; prev_v = 0; pending = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      if (resp_valid) begin
        t_got = 1; t_lat = cyc; t_rdata = resp_rdata; t_hit = resp_hit;
        break;
      end
      if (req_ready) t_busy_ok = 0;
      if (mem_req_valid) begin
        if (!prev_v) begin
          t_n_mem++; m_addr = mem_req_addr; m_wr = mem_req_wr; m_wdata = mem_req_wdata; held = 0;
        end else if (mem_req_addr !== m_addr || mem_req_wdata !== m_wdata || mem_req_wr !== m_wr) begin
          t_stable = 0;
        end
        if (held >= ready_delay) begin mem_req_ready = 1'b1; pending = 1; end
        else held++;
      end else if (pending) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = m_wr ? 32'h0 : ram[m_addr[7:0]];
        if (m_wr) ram[m_addr[7:0]] = m_wdata;
        pending = 0;
      end
      prev_v = mem_req_valid;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready_low got=%b exp=0", req_ready); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if ({resp_valid, resp_hit, mem_req_valid, mem_req_wr} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_hit, mem_req_valid, mem_req_wr}); end
    checks++; if ({resp_rdata, mem_req_addr, mem_req_wdata} !== 96'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {resp_rdata, mem_req_addr, mem_req_wdata}); end
    checks++; if ({hit_count, miss_count} !== 64'h0) begin failures++; $display("FAIL reset_counters got=%h exp=0", {hit_count, miss_count}); end
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_cold_read();
    run_req(1'b0, 32'h25, 32'h0, 0);
    checks++; if (t_got !== 1'b1) begin failures++; $display("FAIL cold_timeout got=%b exp=1", t_got); end
    checks++; if (t_n_mem != 1 || m_wr !== 1'b0 || m_addr !== 32'h25) begin failures++; $display("FAIL cold_memreq n=%0d wr=%b addr=%h exp n=1 wr=0 addr=25", t_n_mem, m_wr, m_addr); end
    checks++; if (t_rdata !== 32'hDEADBEEF || t_hit !== 1'b0) begin failures++; $display("FAIL cold_resp got=%h/%b exp=deadbeef/0", t_rdata, t_hit); end
    checks++; if (t_lat != 4) begin failures++; $display("FAIL cold_latency got=%0d exp=4", t_lat); end
    checks++; if (miss_count !== 32'd1) begin failures++; $display("FAIL cold_miss_count got=%0d exp=1", miss_count); end
    run_req(1'b0, 32'h25, 32'h0, 0);
    checks++; if (t_n_mem != 0) begin failures++; $display("FAIL rehit_memreq got=%0d exp=0", t_n_mem); end
    checks++; if (t_rdata !== 32'hDEADBEEF || t_hit !== 1'b1) begin failures++; $display("FAIL rehit_resp got=%h/%b exp=deadbeef/1", t_rdata, t_hit); end
    checks++; if (t_lat != 2) begin failures++; $display("FAIL rehit_latency got=%0d exp=2", t_lat); end
    checks++; if (hit_count !== 32'd1) begin failures++; $display("FAIL rehit_hit_count got=%0d exp=1", hit_count); end
  endtask

  task automatic test_write_then_read();
    run_req(1'b1, 32'h10, 32'h1234, 0);
    checks++; if (t_n_mem != 1 || m_wr !== 1'b1 || m_addr !== 32'h10 || m_wdata !== 32'h1234) begin failures++; $display("FAIL wr_memreq n=%0d wr=%b addr=%h data=%h exp 1/1/10/1234", t_n_mem, m_wr, m_addr, m_wdata); end
    checks++; if (t_hit !== 1'b0 || miss_count !== 32'd2) begin failures++; $display("FAIL wr_miss hit=%b miss=%0d exp 0/2", t_hit, miss_count); end
    run_req(1'b0, 32'h10, 32'h0, 0);
    checks++; if (t_n_mem != 0 || t_hit !== 1'b1 || t_rdata !== 32'h1234) begin failures++; $display("FAIL rd_after_wr n=%0d hit=%b data=%h exp 0/1/1234", t_n_mem, t_hit, t_rdata); end
    checks++; if (hit_count !== 32'd2) begin failures++; $display("FAIL rd_after_wr_hits got=%0d exp=2", hit_count); end
  endtask

  task automatic test_write_hit();
    apply_reset();
    run_req(1'b0, 32'h07, 32'h0, 0);
    run_req(1'b1, 32'h07, 32'hCAFE, 0);
    checks++; if (t_n_mem != 1 || m_wr !== 1'b1 || m_wdata !== 32'hCAFE) begin failures++; $display("FAIL wrhit_memreq n=%0d wr=%b data=%h exp 1/1/cafe", t_n_mem, m_wr, m_wdata); end
    checks++; if (t_hit !== 1'b1 || t_rdata !== 32'hA5000007) begin failures++; $display("FAIL wrhit_resp hit=%b data=%h exp 1/a5000007", t_hit, t_rdata); end
    run_req(1'b0, 32'h07, 32'h0, 0);
    checks++; if (t_n_mem != 0 || t_rdata !== 32'hCAFE || t_lat != 2) begin failures++; $display("FAIL wrhit_readback n=%0d data=%h lat=%0d exp 0/cafe/2", t_n_mem, t_rdata, t_lat); end
    checks++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin failures++; $display("FAIL wrhit_counters hit=%0d miss=%0d exp 2/1", hit_count, miss_count); end
  endtask

  task automatic test_eviction();
    logic [31:0] seq [0:3];
    apply_reset();
    seq[0] = 32'h00; seq[1] = 32'h10; seq[2] = 32'h20; seq[3] = 32'h30;
    for (int i = 0; i < 4; i++) run_req(1'b0, seq[i], 32'h0, 0);
    run_req(1'b0, 32'h00, 32'h0, 0);
    checks++; if (t_n_mem != 0 || t_hit !== 1'b1) begin failures++; $display("FAIL evict_touch0 n=%0d hit=%b exp 0/1", t_n_mem, t_hit); end
    run_req(1'b0, 32'h40, 32'h0, 0);
    checks++; if (t_n_mem != 1 || t_rdata !== 32'hA5000040) begin failures++; $display("FAIL evict_fill40 n=%0d data=%h exp 1/a5000040", t_n_mem, t_rdata); end
    run_req(1'b0, 32'h00, 32'h0, 0);
    checks++; if (t_n_mem != 0 || t_hit !== 1'b1 || t_rdata !== 32'hA5000000) begin failures++; $display("FAIL evict_keep0 n=%0d hit=%b data=%h exp 0/1/a5000000", t_n_mem, t_hit, t_rdata); end
    run_req(1'b0, 32'h10, 32'h0, 0);
    checks++; if (t_n_mem != 1 || t_hit !== 1'b0) begin failures++; $display("FAIL evict_lost10 n=%0d hit=%b exp 1/0", t_n_mem, t_hit); end
    checks++; if (hit_count !== 32'd2 || miss_count !== 32'd6) begin failures++; $display("FAIL evict_counters hit=%0d miss=%0d exp 2/6", hit_count, miss_count); end
  endtask

  task automatic test_ready_stall();
    run_req(1'b0, 32'h33, 32'h0, 5);
    checks++; if (t_got !== 1'b1 || t_n_mem != 1) begin failures++; $display("FAIL stall_single got=%b n=%0d exp 1/1", t_got, t_n_mem); end
    checks++; if (t_stable !== 1'b1 || m_addr !== 32'h33) begin failures++; $display("FAIL stall_stable stable=%b addr=%h exp 1/33", t_stable, m_addr); end
    checks++; if (t_busy_ok !== 1'b1) begin failures++; $display("FAIL stall_req_ready got=%b exp=1 (never ready while busy)", t_busy_ok); end
    checks++; if (t_rdata !== 32'hA5000033 || t_lat != 9) begin failures++; $display("FAIL stall_resp data=%h lat=%0d exp a5000033/9", t_rdata, t_lat); end
  endtask

  task automatic test_rst_mid();
    logic seen;
    apply_reset();
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h55;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL rstmid_memreq got=%b exp=1", mem_req_valid); end
    mem_req_ready = 1'b1;
    @(negedge clk); mem_req_ready = 1'b0;
    checks++; if (dbg_state !== 3'd3) begin failures++; $display("FAIL rstmid_in_wait got=%0d exp=3", dbg_state); end
    rst = 1'b1;
    #1;
    checks++; if (dbg_state !== 3'd0 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_async st=%0d mv=%b rv=%b rdy=%b exp 0/0/0/0", dbg_state, mem_req_valid, resp_valid, req_ready); end
    @(negedge clk); rst = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = 32'h5555AAAA;
    @(negedge clk); mem_resp_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0 || dbg_state !== 3'd0) begin failures++; $display("FAIL rstmid_stray seen=%b st=%0d exp 0/0", seen, dbg_state); end
    checks++; if (miss_count !== 32'd0 || resp_rdata !== 32'h0) begin failures++; $display("FAIL rstmid_cleared miss=%0d rdata=%h exp 0/0", miss_count, resp_rdata); end
    run_req(1'b0, 32'h55, 32'h0, 0);
    checks++; if (t_n_mem != 1 || t_hit !== 1'b0 || t_rdata !== 32'hA5000055) begin failures++; $display("FAIL rstmid_nofill n=%0d hit=%b data=%h exp 1/0/a5000055", t_n_mem, t_hit, t_rdata); end
  endtask

  task automatic test_flush();
    apply_reset();
    run_req(1'b0, 32'h01, 32'h0, 0);
    run_req(1'b0, 32'h02, 32'h0, 0);
    run_req(1'b0, 32'h03, 32'h0, 0);
    run_req(1'b0, 32'h01, 32'h0, 0);
    checks++; if (t_hit !== 1'b1) begin failures++; $display("FAIL flush_prehit got=%b exp=1", t_hit); end
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h02;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    checks++; if (dbg_state !== 3'd0) begin failures++; $display("FAIL flush_priority st=%0d exp=0", dbg_state); end
    checks++; if (hit_count !== 32'd1 || miss_count !== 32'd3) begin failures++; $display("FAIL flush_counters hit=%0d miss=%0d exp 1/3", hit_count, miss_count); end
    run_req(1'b0, 32'h02, 32'h0, 0);
    checks++; if (t_n_mem != 1 || t_hit !== 1'b0 || miss_count !== 32'd4) begin failures++; $display("FAIL flush_reread n=%0d hit=%b miss=%0d exp 1/0/4", t_n_mem, t_hit, miss_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 | i;
    ram[8'h25] = 32'hDEADBEEF;
    test_reset();
    test_cold_read();
    test_write_then_read();
    test_write_hit();
    test_eviction();
    test_ready_stall();
    test_rst_mid();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_nway.md
# cache_nway

Parametrised N-way set-associative, write-through, write-allocate cache with true-LRU replacement, sitting between a CPU-side request port and the word-addressed RAM model. It replaces the fixed 4-way block with configurable ways, sets and widths. It adds a valid/ready handshake on both sides, a one-cycle flush, and hit/miss statistics counters.

## Interface
- WAYS, 4, associativity; power of two, ≥2
- SETS, 16, number of sets; power of two, ≥2
- ADDR_W, 32, word-address width
- DATA_W, 32, data width; one word per line
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  cache can accept; high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- flush  in  1  invalidate all lines; honoured only in IDLE, has priority over req_valid
- resp_valid  out  1  one-cycle completion pulse; no backpressure
- resp_rdata  out  DATA_W  read data, held until next resp_valid
- resp_hit  out  1  1 if the request hit, held with resp_rdata
- mem_req_valid, mem_req_ready  out/in  1  memory request handshake
- mem_req_wr  out  1;  mem_req_addr  out  ADDR_W;  mem_req_wdata  out  DATA_W
- mem_resp_valid  in  1;  mem_resp_rdata  in  DATA_W  memory completion
- hit_count, miss_count  out  32  saturating statistics counters

## Operation
- Address split: index = req_addr[IDX_W-1:0], IDX_W = clog2(SETS); tag = req_addr[ADDR_W-1:IDX_W].
- States: IDLE → LOOKUP → (RESP | MEM_REQ) ; MEM_REQ → MEM_WAIT on mem_req_ready ; MEM_WAIT → RESP on mem_resp_valid ; RESP → IDLE.
- IDLE: if flush, clear all valid bits and reset LRU ages; stay IDLE. Else on req_valid&&req_ready, latch wr/addr/wdata and go to LOOKUP.
- LOOKUP: compare the tag against all WAYS in parallel; hit = any valid way with matching tag. At most one way may match.
- Read hit: hit_count++, update LRU, resp_rdata = line, resp_hit = 1, go to RESP.
- Read miss: miss_count++, MEM_REQ read. On mem_resp_valid, write the victim way (data, tag, valid = 1), update LRU, resp_rdata = mem data, resp_hit = 0.
- Write: always MEM_REQ write (write-through). On a hit, update the hit way's data in LOOKUP and hit_count++. On a miss, allocate the victim with wdata/tag and miss_count++. In both cases update LRU. resp after mem_resp_valid; resp_rdata unchanged; resp_hit = lookup result.
- LRU: per-line age of clog2(WAYS) bits; 0 = MRU. Access to way w with age a: every way with age < a increments, and w becomes 0. Reset/flush: age[i] = i.
- Victim: the lowest-index invalid way. If all ways are valid, the way with age WAYS-1.
- Counters saturate at 32'hFFFF_FFFF; flush does not clear them.

## Timing
- Reset values: req_ready 0 during rst, 1 after in IDLE. resp_valid, resp_hit, mem_req_valid, mem_req_wr = 0. resp_rdata, mem_req_addr, mem_req_wdata = 0. Counters 0. All valid bits 0. state IDLE.
- Read hit: accepted edge at cycle 0, LOOKUP cycle 1, resp_valid high in cycle 2. Throughput is one request per 3 cycles.
- Miss or write: mem_req_valid rises in the cycle after LOOKUP. It holds stable with addr/data until mem_req_ready, then drops. resp_valid is high in the cycle after the mem_resp_valid edge.
- mem_resp_valid is ignored outside MEM_WAIT. A response arriving in the same cycle as mem_req_ready is not accepted.
- rst mid-transaction: immediate return to IDLE. Any in-flight memory access is abandoned, and a later stray mem_resp_valid is ignored. No partial fill occurs.
- Flush asserted outside IDLE is ignored. It is not queued.

## Structure
- cache_pkg: state enum (IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP); clog2-derived localparams IDX_W, TAG_W, AGE_W as functions of the parameters.
- Sub-module cache_lru: takes one set's age vector, valid vector and the accessed way. It outputs the updated age vector and the victim way index. The top module instantiates it once, on the latched index.
- Storage: data, tag, valid and age arrays are indexed by set*WAYS+way. They are register-based, not inferred RAM.

## Test plan
- Cold read addr 0x25, RAM[0x25]=0xDEADBEEF → one mem read; resp_rdata=0xDEADBEEF, resp_hit=0, miss_count=1. Repeat → no mem request, resp_hit=1 in cycle 2, hit_count=1.
- Write 0x10←0x1234 then read 0x10 → mem write issued. The read hits with 0x1234 and no mem read is issued.
- WAYS=4, SETS=16: read 0x00,0x10,0x20,0x30, then 0x00, then 0x40 → 0x10 is evicted. A read of 0x00 then hits; a read of 0x10 misses.
- Hold mem_req_ready low 5 cycles during a miss → mem_req_valid and mem_req_addr stay stable; req_ready stays 0; a single response follows.
- Assert rst while in MEM_WAIT, then pulse mem_resp_valid → state IDLE, all outputs at reset values, no line valid, no resp_valid.
- Fill 3 lines, pulse flush in IDLE, re-read one → miss; counters are retained across the flush.
